// File: rtl/servo_pwm_gen_pkg.sv
// Shared types and helpers for the servo PWM generator: FSM state encoding,
// the microsecond datapath width and the pulse-width range clamp.
package servo_pkg;

    localparam int US_W = 16;

    typedef enum logic [1:0] {
        DISABLED,
        START,
        HIGH,
        LOW
    } servo_state_t;

    // Limit a requested pulse width to the permitted [lo, hi] window.
    function automatic logic [US_W-1:0] clamp_us(
        input logic [US_W-1:0] value,
        input logic [US_W-1:0] lo,
        input logic [US_W-1:0] hi
    );
        logic [US_W-1:0] result;
        result = value;
        if (value < lo) begin
            result = lo;
        end else if (value > hi) begin
            result = hi;
        end
        return result;
    endfunction

endpackage

// File: rtl/servo_pwm_gen_us_tick.sv
// Microsecond prescaler: counts system clocks 0..DIV-1 and flags the last
// clock of each microsecond. The synchronous clear realigns the count to the
// start of a PWM frame.
module servo_us_tick
    import servo_pkg::*;
#(
    parameter int DIV = 100
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            clear,
    output logic            tick,
    output logic [US_W-1:0] count
);

    localparam logic [US_W-1:0] LAST = US_W'(DIV - 1);

    assign tick = (count == LAST);

    // Free-running prescaler, restarted at reset and at every frame start.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/servo_pwm_gen.sv
// 50 Hz hobby-servo PWM generator. Software requests are captured at any
// time but only applied at a frame boundary, optionally slew-limited, so the
// output never produces a truncated or glitched pulse.
module servo_pwm_gen
    import servo_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int FRAME_US    = 20000,
    parameter int MIN_US      = 500,
    parameter int MAX_US      = 2500
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            cfg_valid,
    input  logic [US_W-1:0] cfg_pulse_us,
    input  logic [US_W-1:0] cfg_slew_us,
    input  logic            cfg_enable,
    output logic            servo_pwm,
    output logic            frame_start,
    output logic [US_W-1:0] cur_pulse_us,
    output logic            clamped
);

    localparam int DIV = CLK_FREQ_HZ / 1_000_000;

    localparam logic [US_W-1:0] MIN_V = US_W'(MIN_US);
    localparam logic [US_W-1:0] MAX_V = US_W'(MAX_US);
    localparam logic [US_W-1:0] MID_V = US_W'((MIN_US + MAX_US) / 2);

    // Counting starts on frame cycle 1, so the last frame cycle
    // (FRAME_US*DIV-1) is reached one prescaler step before the final tick.
    localparam int END_US_I  = (DIV >= 2) ? FRAME_US - 1 : FRAME_US - 2;
    localparam int END_PRE_I = (DIV >= 2) ? DIV - 2 : 0;
    localparam logic [US_W-1:0] END_US  = US_W'(END_US_I);
    localparam logic [US_W-1:0] END_PRE = US_W'(END_PRE_I);

    servo_state_t    state;
    logic [US_W-1:0] pending;
    logic [US_W-1:0] slew;
    logic [US_W-1:0] us_cnt;
    logic [US_W-1:0] pre_cnt;
    logic            tick;
    logic [US_W-1:0] next_cur;
    logic signed [US_W:0] diff;
    logic [US_W:0]   mag;
    logic            high_last;
    logic            frame_last;

    servo_us_tick #(
        .DIV(DIV)
    ) u_tick (
        .clock(clock),
        .reset(reset),
        .clear(state == START),
        .tick (tick),
        .count(pre_cnt)
    );

    assign high_last  = tick && (us_cnt == cur_pulse_us - 1'b1);
    assign frame_last = (us_cnt == END_US) && (pre_cnt == END_PRE);

    // Microsecond position within the frame; held outside active frames.
    always_ff @(posedge clock) begin
        if (reset || state == START) begin
            us_cnt <= '0;
        end else if (tick && (state == HIGH || state == LOW)) begin
            us_cnt <= us_cnt + 1'b1;
        end
    end

    // Latch the most recent software request, clamped into range.
    always_ff @(posedge clock) begin
        if (reset) begin
            pending <= MID_V;
            slew    <= '0;
            clamped <= 1'b0;
        end else if (cfg_valid) begin
            pending <= clamp_us(cfg_pulse_us, MIN_V, MAX_V);
            slew    <= cfg_slew_us;
            clamped <= (cfg_pulse_us < MIN_V) || (cfg_pulse_us > MAX_V);
        end
    end

    // Width for the next frame: jump to pending, or step by slew toward it.
    always_comb begin
        diff     = $signed({1'b0, pending}) - $signed({1'b0, cur_pulse_us});
        mag      = diff[US_W] ? (~diff + 1'b1) : diff;
        next_cur = pending;
        if (slew != '0 && mag > {1'b0, slew}) begin
            if (diff[US_W]) begin
                next_cur = cur_pulse_us - slew;
            end else begin
                next_cur = cur_pulse_us + slew;
            end
        end
    end

    // Frame sequencer with registered PWM and frame-start outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= DISABLED;
            servo_pwm    <= 1'b0;
            frame_start  <= 1'b0;
            cur_pulse_us <= MID_V;
        end else begin
            frame_start <= 1'b0;
            case (state)
                DISABLED: begin
                    servo_pwm <= 1'b0;
                    if (cfg_enable) begin
                        state       <= START;
                        frame_start <= 1'b1;
                    end
                end
                START: begin
                    cur_pulse_us <= next_cur;
                    if (next_cur != '0) begin
                        state     <= HIGH;
                        servo_pwm <= 1'b1;
                    end else begin
                        state     <= LOW;
                        servo_pwm <= 1'b0;
                    end
                end
                HIGH: begin
                    if (high_last) begin
                        servo_pwm <= 1'b0;
                        if (!frame_last) begin
                            state <= LOW;
                        end else if (cfg_enable) begin
                            state       <= START;
                            frame_start <= 1'b1;
                        end else begin
                            state <= DISABLED;
                        end
                    end
                end
                LOW: begin
                    servo_pwm <= 1'b0;
                    if (frame_last) begin
                        if (cfg_enable) begin
                            state       <= START;
                            frame_start <= 1'b1;
                        end else begin
                            state <= DISABLED;
                        end
                    end
                end
                default: begin
                    state     <= DISABLED;
                    servo_pwm <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_servo_pwm_gen.sv
// Self-checking bench for servo_pwm_gen, run with a scaled-down clock and
// frame so that many frames fit in a short simulation. A frame-level
// reference model predicts every output on every cycle.
module tb_servo_pwm_gen;

    localparam int CLK_HZ     = 2_000_000;
    localparam int DIV        = CLK_HZ / 1_000_000;
    localparam int FRAME      = 600;
    localparam int MINU       = 100;
    localparam int MAXU       = 450;
    localparam int MID        = (MINU + MAXU) / 2;
    localparam int FRAME_CLKS = FRAME * DIV;

    logic        clock;
    logic        reset;
    logic        cfg_valid;
    logic [15:0] cfg_pulse_us;
    logic [15:0] cfg_slew_us;
    logic        cfg_enable;
    logic        servo_pwm;
    logic        frame_start;
    logic [15:0] cur_pulse_us;
    logic        clamped;

    int assert_count = 0;
    int fail_count   = 0;

    // Reference model state.
    bit m_active;
    int m_fc;
    int m_cur;
    int m_pend;
    int m_slew;
    bit m_clamped;

    // Observation records.
    int cur_q[$];
    int hi_q[$];
    int gap_q[$];
    int hi_cnt;
    int since_fs;
    int win_hi;
    int win_fs;

    servo_pwm_gen #(
        .CLK_FREQ_HZ(CLK_HZ),
        .FRAME_US   (FRAME),
        .MIN_US     (MINU),
        .MAX_US     (MAXU)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .cfg_valid   (cfg_valid),
        .cfg_pulse_us(cfg_pulse_us),
        .cfg_slew_us (cfg_slew_us),
        .cfg_enable  (cfg_enable),
        .servo_pwm   (servo_pwm),
        .frame_start (frame_start),
        .cur_pulse_us(cur_pulse_us),
        .clamped     (clamped)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assert_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic int clamp_model(int p);
        if (p < MINU) return MINU;
        if (p > MAXU) return MAXU;
        return p;
    endfunction

    function automatic int slew_model(int cur, int pend, int slew);
        int d;
        d = pend - cur;
        if (slew == 0 || (d < 0 ? -d : d) <= slew) return pend;
        return (d > 0) ? cur + slew : cur - slew;
    endfunction

    task automatic model_reset();
        m_active  = 1'b0;
        m_fc      = 0;
        m_cur     = MID;
        m_pend    = MID;
        m_slew    = 0;
        m_clamped = 1'b0;
    endtask

    // Drive inputs for one clock edge, advance the model, then check outputs.
    task automatic applyStimulus(input bit en, input bit v, input int p, input int s, input bit rst);
        bit exp_fs;
        bit exp_pwm;
        reset        = rst;
        cfg_enable   = en;
        cfg_valid    = v;
        cfg_pulse_us = 16'(p);
        cfg_slew_us  = 16'(s);
        if (rst) begin
            model_reset();
        end else begin
            if (m_active) begin
                if (m_fc == 0) m_cur = slew_model(m_cur, m_pend, m_slew);
                if (m_fc == FRAME_CLKS - 1) begin
                    if (en) m_fc = 0;
                    else m_active = 1'b0;
                end else begin
                    m_fc++;
                end
            end else if (en) begin
                m_active = 1'b1;
                m_fc     = 0;
            end
            if (v) begin
                m_pend    = clamp_model(p);
                m_slew    = s;
                m_clamped = (p < MINU) || (p > MAXU);
            end
        end
        @(negedge clock);
        cfg_valid = 1'b0;
        exp_fs  = m_active && (m_fc == 0);
        exp_pwm = m_active && (m_fc >= 1) && (m_fc <= m_cur * DIV);
        checkOutput("frame_start", 32'(frame_start), 32'(exp_fs));
        checkOutput("servo_pwm", 32'(servo_pwm), 32'(exp_pwm));
        checkOutput("cur_pulse_us", 32'(cur_pulse_us), 32'(m_cur));
        checkOutput("clamped", 32'(clamped), 32'(m_clamped));
        if (m_active && m_fc == 1) cur_q.push_back(int'(cur_pulse_us));
        if (servo_pwm === 1'b1) begin
            hi_cnt++;
            win_hi++;
        end
        since_fs++;
        if (frame_start === 1'b1) begin
            win_fs++;
            hi_q.push_back(hi_cnt);
            gap_q.push_back(since_fs);
            hi_cnt   = 0;
            since_fs = 0;
        end
    endtask

    task automatic run_cycles(input int n, input bit en);
        for (int i = 0; i < n; i++) applyStimulus(en, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic request(input int p, input int s);
        applyStimulus(1'b1, 1'b1, p, s, 1'b0);
    endtask

    // Advance until the model reaches the given frame cycle, within a bound.
    task automatic wait_fc(input int target);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 2 * FRAME_CLKS + 4; i++) begin
            if (m_active && m_fc == target) begin
                hit = 1'b1;
                break;
            end
            applyStimulus(1'b1, 1'b0, 0, 0, 1'b0);
        end
        if (!hit) checkOutput("wait_fc_timeout", 32'(m_fc), 32'(target));
    endtask

    task automatic check_q(input string tag, input int q[$], input int idx, input int expected);
        if (q.size() <= idx) checkOutput({tag, "_missing"}, 32'(q.size()), 32'(idx + 1));
        else checkOutput(tag, 32'(q[idx]), 32'(expected));
    endtask

    initial begin
        int ramp[6];
        bit en_r;
        int rp;
        int rs;
        ramp = '{MID + 20, MID + 40, MID + 60, MID + 80, MID + 100, MID + 100};
        hi_cnt = 0; since_fs = 0; win_hi = 0; win_fs = 0;
        reset = 1'b1; cfg_valid = 1'b0; cfg_pulse_us = '0; cfg_slew_us = '0; cfg_enable = 1'b0;
        model_reset();

        // Reset, then idle disabled.
        applyStimulus(1'b0, 1'b0, 0, 0, 1'b1);
        applyStimulus(1'b0, 1'b0, 0, 0, 1'b1);
        win_fs = 0;
        run_cycles(10, 1'b0);
        checkOutput("idle_no_frame_start", 32'(win_fs), 0);
        checkOutput("idle_cur", 32'(cur_pulse_us), 32'(MID));

        // Default width frames.
        run_cycles(1, 1'b1);
        checkOutput("enable_fs", 32'(frame_start), 1);
        hi_q.delete(); gap_q.delete();
        run_cycles(3 * FRAME_CLKS, 1'b1);
        check_q("frame_gap", gap_q, 0, FRAME_CLKS);
        check_q("frame_gap2", gap_q, 1, FRAME_CLKS);
        check_q("default_high", hi_q, 0, MID * DIV);

        // Out-of-range requests are clamped.
        wait_fc(100);
        request(1000, 0);
        checkOutput("clamp_hi_flag", 32'(clamped), 1);
        hi_q.delete();
        run_cycles(2 * FRAME_CLKS, 1'b1);
        check_q("clamp_hi_width", hi_q, 1, MAXU * DIV);
        request(20, 0);
        checkOutput("clamp_lo_flag", 32'(clamped), 1);
        hi_q.delete();
        run_cycles(2 * FRAME_CLKS, 1'b1);
        check_q("clamp_lo_width", hi_q, 1, MINU * DIV);

        // Slew-limited ramp upward.
        request(MID, 0);
        checkOutput("in_range_flag", 32'(clamped), 0);
        run_cycles(FRAME_CLKS, 1'b1);
        request(MID + 100, 20);
        cur_q.delete();
        run_cycles(7 * FRAME_CLKS, 1'b1);
        for (int i = 0; i < 6; i++) check_q("ramp", cur_q, i, ramp[i]);

        // Target changed mid-ramp: must land exactly, no overshoot.
        request(MID, 0);
        run_cycles(FRAME_CLKS, 1'b1);
        wait_fc(100);
        request(MID + 100, 20);
        cur_q.delete();
        run_cycles(2 * FRAME_CLKS - 1, 1'b1);
        request(MID + 55, 20);
        run_cycles(2 * FRAME_CLKS, 1'b1);
        check_q("reverse0", cur_q, 0, MID + 20);
        check_q("reverse1", cur_q, 1, MID + 40);
        check_q("reverse2", cur_q, 2, MID + 55);
        check_q("reverse3", cur_q, 3, MID + 55);

        // Enable dropped mid-pulse: pulse and frame still complete.
        wait_fc(120);
        win_hi = 0; win_fs = 0;
        run_cycles(2 * FRAME_CLKS, 1'b0);
        checkOutput("drop_pulse_rest", 32'(win_hi), 32'((MID + 55) * DIV - 120));
        checkOutput("drop_no_frame", 32'(win_fs), 0);
        checkOutput("drop_pwm_low", 32'(servo_pwm), 0);

        // Request coincident with frame_start applies one frame later.
        run_cycles(1, 1'b1);
        checkOutput("reenable_fs", 32'(frame_start), 1);
        cur_q.delete();
        request(200, 0);
        run_cycles(2 * FRAME_CLKS, 1'b1);
        check_q("coincident_old", cur_q, 0, MID + 55);
        check_q("coincident_new", cur_q, 1, 200);

        // Randomised requests and enable toggles.
        en_r = 1'b1;
        for (int c = 0; c < 12 * FRAME_CLKS; c++) begin
            if ($urandom_range(0, 399) == 0) begin
                rp = int'($urandom_range(0, 600));
                rs = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 100));
                applyStimulus(en_r, 1'b1, rp, rs, 1'b0);
            end else begin
                if ($urandom_range(0, 2999) == 0) en_r = !en_r;
                applyStimulus(en_r, 1'b0, 0, 0, 1'b0);
            end
        end

        // Reset while the pulse is high.
        wait_fc(10);
        checkOutput("pre_reset_pwm", 32'(servo_pwm), 1);
        applyStimulus(1'b1, 1'b0, 0, 0, 1'b1);
        checkOutput("reset_pwm", 32'(servo_pwm), 0);
        checkOutput("reset_cur", 32'(cur_pulse_us), 32'(MID));
        checkOutput("reset_clamped", 32'(clamped), 0);
        checkOutput("reset_fs", 32'(frame_start), 0);
        run_cycles(5, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule

// File: doc/servo_pwm_gen.md
Name: servo_pwm_gen

Overview:
Downstream consumer of the servo core's AXI4-Lite register file. It takes the pulse-width and slew configuration written by software and generates a glitch-free 50 Hz hobby-servo PWM output. New settings are applied only at frame boundaries, with optional per-frame slew limiting and range clamping. The output pin drives the RC car steering servo.

Parameters:
CLK_FREQ_HZ, 100_000_000, system clock frequency; must be an integer multiple of 1 MHz.
FRAME_US, 20000, PWM frame length in microseconds; maximum 65535.
MIN_US, 500, minimum permitted pulse width in microseconds.
MAX_US, 2500, maximum permitted pulse width in microseconds; must satisfy MIN_US <= MAX_US < FRAME_US.

Ports:
clock  in  1  system clock; all logic is on the rising edge.
reset  in  1  synchronous, active-high reset.
cfg_valid  in  1  single-cycle strobe: the register file has written new cfg_pulse_us / cfg_slew_us values.
cfg_pulse_us  in  16  requested pulse width in microseconds; sampled only when cfg_valid=1.
cfg_slew_us  in  16  maximum change per frame in microseconds; 0 means no limit. Sampled when cfg_valid=1.
cfg_enable  in  1  level signal; 1 = generate frames.
servo_pwm  out  1  registered PWM output.
frame_start  out  1  one-cycle pulse on each START cycle.
cur_pulse_us  out  16  pulse width used in the current frame.
clamped  out  1  the last accepted request was outside [MIN_US, MAX_US].

Behaviour:
- Derived constant: DIV = CLK_FREQ_HZ/1_000_000 clocks per microsecond (100 at the default clock).
- Reset values:
  - servo_pwm=0, frame_start=0, clamped=0.
  - cur_pulse_us = pending = (MIN_US+MAX_US)/2, which is 1500 at the defaults.
  - slew=0, state=DISABLED, all counters 0.
- Request capture, on a cycle with cfg_valid=1:
  - pending <= clamp(cfg_pulse_us, MIN_US, MAX_US) on the next edge.
  - slew <= cfg_slew_us.
  - clamped <= 1 if cfg_pulse_us<MIN_US or cfg_pulse_us>MAX_US, else 0.
  - Each new request overwrites the previous one; no queueing.
- FSM states: DISABLED, START, HIGH, LOW.
  - DISABLED: servo_pwm=0. Go to START when cfg_enable=1.
  - START (frame cycle 0, exactly 1 clock):
    - frame_start=1.
    - d = pending - cur_pulse_us, computed 17-bit signed.
    - If slew==0 or |d|<=slew: cur_pulse_us <= pending.
    - Otherwise: cur_pulse_us <= cur_pulse_us ± slew, moving toward pending.
    - Then go to HIGH.
  - HIGH: servo_pwm=1 for exactly cur_pulse_us*DIV cycles, starting at frame cycle 1. Then go to LOW.
  - LOW: servo_pwm=0 until frame cycle FRAME_US*DIV-1 inclusive.
    - Then go to START if cfg_enable=1, else DISABLED.
- Frame period is exactly FRAME_US*DIV clocks, which is 2,000,000 at the defaults.
- cfg_valid on the START cycle itself: START uses the old pending value; the new value takes effect at the next START.
- cfg_enable falling mid-frame: the current frame completes unchanged, with no truncated pulse. DISABLED is entered at the frame end.
- cfg_enable rising: START occurs on the next clock.
- Reset mid-pulse: servo_pwm is 0 after the reset edge and all state returns to the reset values.
- Counters:
  - The microsecond prescaler counts 0..DIV-1.
  - The microsecond counter is 16 bits wide.
  - Both counters clear in START. Neither wraps inside a frame.
- Arithmetic:
  - ± slew saturates at pending; it never overshoots.
  - All unsigned values are 16 bits.
- Latency: a request is visible on cur_pulse_us on the cycle after the next START.

Decomposition:
- Package servo_pkg:
  - state enum servo_state_t {DISABLED, START, HIGH, LOW}.
  - US_W=16.
  - Function clamp_us().
- Sub-module servo_us_tick: the DIV prescaler that produces a 1-µs tick pulse, with a synchronous clear input driven by START.

Test Plan:
- Reset, then hold for 10 cycles → servo_pwm=0, cur_pulse_us=1500, clamped=0, frame_start never asserted.
- cfg_enable=1 with the default 1500 µs → servo_pwm high for exactly 150,000 clocks per frame; frame_start pulses are exactly 2,000,000 clocks apart.
- cfg_valid with pulse=3000 → clamped=1 and the next frame is high for 250,000 clocks. Then cfg_valid with pulse=200 → clamped stays 1 and the frame after is 50,000 clocks high.
- slew=100, pulse changed 1500→2000 → cur_pulse_us over successive frames is 1600, 1700, 1800, 1900, 2000, then stays at 2000. Reversing to 1950 mid-ramp lands exactly at 1950 with no overshoot.
- cfg_enable dropped 300 µs into a 1500 µs pulse → the pulse completes its full 150,000 clocks, the frame ends on schedule, then the FSM is DISABLED with servo_pwm=0 and no further frame_start.
- cfg_valid coincident with frame_start → the new value is applied one frame later. Reset asserted mid-HIGH → servo_pwm=0 on the next cycle and all outputs return to their reset values.
